// File: rtl/prog_stream_loader.sv
// Program loader: turns a header/address/data word stream into imem line writes
// and dmem word writes, and holds prog_loading until a DONE header arrives.
//
// state | meaning
// ------+---------------------------------------------------------------
// HDR   | waiting for a segment header (target + word count)
// ADDR  | waiting for the segment base byte address
// DATA  | streaming segment words into imem lines or dmem words
// FLUSH | padding and writing out a partial imem line, stream stalled
// DONE  | load finished (or aborted on reserved target), stream ignored
module prog_stream_loader #(
    parameter int INSN_LEN    = 32,
    parameter int FETCH_WIDTH = 4,
    parameter int ADDR_LEN    = 32,
    parameter int CNT_W       = 16,
    parameter logic [INSN_LEN-1:0] PAD_INSN = 32'h00000013
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [INSN_LEN-1:0]             in_data,
    output logic                            in_ready,
    output logic                            prog_loading,
    output logic [ADDR_LEN-1:0]             ld_addr,
    output logic [FETCH_WIDTH*INSN_LEN-1:0] ld_line,
    output logic [INSN_LEN-1:0]             ld_word,
    output logic                            imem_we,
    output logic                            dmem_we,
    output logic                            err
);

    localparam int LINE_W     = FETCH_WIDTH * INSN_LEN;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int LANE_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    localparam logic [ADDR_LEN-1:0] LINE_STEP = ADDR_LEN'(LINE_BYTES);
    localparam logic [ADDR_LEN-1:0] LINE_MASK = ~(LINE_STEP - ADDR_LEN'(1));
    localparam logic [ADDR_LEN-1:0] WORD_STEP = ADDR_LEN'(4);
    localparam logic [ADDR_LEN-1:0] WORD_MASK = ~ADDR_LEN'(3);
    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(FETCH_WIDTH - 1);
    localparam logic [LINE_W-1:0]   PAD_LINE  = {FETCH_WIDTH{PAD_INSN}};

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_DATA,
        S_FLUSH,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        TGT_IMEM = 2'b00,
        TGT_DMEM = 2'b01,
        TGT_RSVD = 2'b10,
        TGT_DONE = 2'b11
    } tgt_t;

    state_t              state;
    logic                tgt_dmem;
    logic [CNT_W-1:0]    cnt_left;
    logic [ADDR_LEN-1:0] base;
    logic [ADDR_LEN-1:0] off;
    logic [LANE_W-1:0]   lane;
    logic [LINE_W-1:0]   line_buf;
    logic [LINE_W-1:0]   line_ins;

    logic                xfer;
    tgt_t                hdr_tgt;
    logic [CNT_W-1:0]    hdr_cnt;
    logic [ADDR_LEN-1:0] addr_in;
    logic                lane_last;
    logic                word_last;

    assign xfer      = in_valid && in_ready;
    assign hdr_tgt   = tgt_t'(in_data[INSN_LEN-1 -: 2]);
    assign hdr_cnt   = in_data[CNT_W-1:0];
    assign addr_in   = ADDR_LEN'(in_data);
    assign lane_last = (lane == LAST_LANE);
    assign word_last = (cnt_left == CNT_W'(1));

    // Lane 0 lands in the MSBs so the first fetched instruction leads the line.
    always_comb begin
        line_ins = line_buf;
        line_ins[(FETCH_WIDTH - 1 - int'(lane)) * INSN_LEN +: INSN_LEN] = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_HDR;
            tgt_dmem     <= 1'b0;
            cnt_left     <= '0;
            base         <= '0;
            off          <= '0;
            lane         <= '0;
            line_buf     <= PAD_LINE;
            in_ready     <= 1'b1;
            prog_loading <= 1'b1;
            ld_addr      <= '0;
            ld_line      <= '0;
            ld_word      <= '0;
            imem_we      <= 1'b0;
            dmem_we      <= 1'b0;
            err          <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            case (state)
                S_HDR: begin
                    if (xfer) begin
                        lane     <= '0;
                        off      <= '0;
                        line_buf <= PAD_LINE;
                        cnt_left <= hdr_cnt;
                        tgt_dmem <= (hdr_tgt == TGT_DMEM);
                        case (hdr_tgt)
                            TGT_DONE: begin
                                state        <= S_DONE;
                                in_ready     <= 1'b0;
                                prog_loading <= 1'b0;
                            end
                            TGT_RSVD: begin
                                state        <= S_DONE;
                                in_ready     <= 1'b0;
                                prog_loading <= 1'b0;
                                err          <= 1'b1;
                            end
                            default: state <= S_ADDR;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (xfer) begin
                        base  <= addr_in & (tgt_dmem ? WORD_MASK : LINE_MASK);
                        state <= (cnt_left == '0) ? S_HDR : S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        cnt_left <= cnt_left - CNT_W'(1);
                        if (tgt_dmem) begin
                            ld_word <= in_data;
                            ld_addr <= base + off;
                            dmem_we <= 1'b1;
                            off     <= off + WORD_STEP;
                            if (word_last)
                                state <= S_HDR;
                        end else if (lane_last) begin
                            ld_line  <= line_ins;
                            ld_addr  <= base + off;
                            imem_we  <= 1'b1;
                            off      <= off + LINE_STEP;
                            lane     <= '0;
                            line_buf <= PAD_LINE;
                            if (word_last)
                                state <= S_HDR;
                        end else begin
                            lane     <= lane + LANE_W'(1);
                            line_buf <= line_ins;
                            if (word_last) begin
                                state    <= S_FLUSH;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    // Unfilled lanes already hold PAD_INSN from the line reset.
                    ld_line  <= line_buf;
                    ld_addr  <= base + off;
                    imem_we  <= 1'b1;
                    off      <= off + LINE_STEP;
                    lane     <= '0;
                    line_buf <= PAD_LINE;
                    state    <= S_HDR;
                    in_ready <= 1'b1;
                end
                S_DONE: begin
                    in_ready     <= 1'b0;
                    prog_loading <= 1'b0;
                end
                default: begin
                    state    <= S_HDR;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_stream_loader.sv
// Directed bench for prog_stream_loader with FETCH_WIDTH=4 and 32-bit words.
module tb_prog_stream_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         prog_loading;
    logic [31:0]  ld_addr;
    logic [127:0] ld_line;
    logic [31:0]  ld_word;
    logic         imem_we;
    logic         dmem_we;
    logic         err;

    int checks   = 0;
    int failures = 0;

    prog_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .prog_loading (prog_loading),
        .ld_addr      (ld_addr),
        .ld_line      (ld_line),
        .ld_word      (ld_word),
        .imem_we      (imem_we),
        .dmem_we      (dmem_we),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word for a single clock edge; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic [31:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_loading"}, 128'(prog_loading), 128'(1));
        chk({tag, "_ready"},   128'(in_ready),     128'(1));
        chk({tag, "_imem_we"}, 128'(imem_we),      128'(0));
        chk({tag, "_dmem_we"}, 128'(dmem_we),      128'(0));
        chk({tag, "_err"},     128'(err),          128'(0));
        chk({tag, "_addr"},    128'(ld_addr),      128'(0));
        chk({tag, "_line"},    ld_line,            128'(0));
        chk({tag, "_word"},    128'(ld_word),      128'(0));
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;

        // Full imem line, no flush
        send(32'h0000_0004);
        send(32'h0000_0000);
        send(32'hA000_0000);
        send(32'hA111_1111);
        send(32'hA222_2222);
        chk("full_no_early_we", 128'(imem_we), 128'(0));
        send(32'hA333_3333);
        chk("full_we",    128'(imem_we), 128'(1));
        chk("full_addr",  128'(ld_addr), 128'(32'h0));
        chk("full_line",  ld_line, {32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333});
        chk("full_ready", 128'(in_ready), 128'(1));
        idle();
        chk("full_we_1cyc", 128'(imem_we), 128'(0));
        chk("full_noflush", 128'(in_ready), 128'(1));

        // Partial imem: 6 words at 0x10
        send(32'h0000_0006);
        send(32'h0000_0010);
        send(32'hB000_0000);
        send(32'hB111_1111);
        send(32'hB222_2222);
        send(32'hB333_3333);
        chk("part_we0",    128'(imem_we), 128'(1));
        chk("part_addr0",  128'(ld_addr), 128'(32'h10));
        chk("part_line0",  ld_line, {32'hB000_0000, 32'hB111_1111, 32'hB222_2222, 32'hB333_3333});
        send(32'hB444_4444);
        chk("part_mid_we", 128'(imem_we), 128'(0));
        send(32'hB555_5555);
        chk("part_last_we",   128'(imem_we),  128'(0));
        chk("part_flush_rdy", 128'(in_ready), 128'(0));
        idle();
        chk("part_we1",    128'(imem_we),  128'(1));
        chk("part_addr1",  128'(ld_addr),  128'(32'h20));
        chk("part_line1",  ld_line, {32'hB444_4444, 32'hB555_5555, 32'h0000_0013, 32'h0000_0013});
        chk("part_rdy_back", 128'(in_ready), 128'(1));
        idle();
        chk("part_we_1cyc", 128'(imem_we), 128'(0));

        // dmem, unaligned base 0x103 -> 0x100
        send(32'h4000_0003);
        send(32'h0000_0103);
        send(32'h0000_0011);
        chk("dm0_we",   128'(dmem_we), 128'(1));
        chk("dm0_addr", 128'(ld_addr), 128'(32'h100));
        chk("dm0_word", 128'(ld_word), 128'(32'h11));
        send(32'h0000_0022);
        chk("dm1_addr", 128'(ld_addr), 128'(32'h104));
        chk("dm1_word", 128'(ld_word), 128'(32'h22));
        send(32'h0000_0033);
        chk("dm2_we",   128'(dmem_we), 128'(1));
        chk("dm2_addr", 128'(ld_addr), 128'(32'h108));
        chk("dm2_word", 128'(ld_word), 128'(32'h33));
        chk("dm_imem_quiet", 128'(imem_we), 128'(0));
        idle();
        chk("dm_we_off", 128'(dmem_we), 128'(0));

        // Zero-count segment returns to HDR without strobes
        send(32'h0000_0000);
        send(32'h0000_0040);
        chk("zero_imem_we", 128'(imem_we),  128'(0));
        chk("zero_dmem_we", 128'(dmem_we),  128'(0));
        chk("zero_ready",   128'(in_ready), 128'(1));

        // dmem with in_valid toggling
        send(32'h4000_0002);
        send(32'h0000_0200);
        idle();
        chk("stall0_we", 128'(dmem_we), 128'(0));
        send(32'h0000_0055);
        chk("stall1_we",   128'(dmem_we), 128'(1));
        chk("stall1_addr", 128'(ld_addr), 128'(32'h200));
        chk("stall1_word", 128'(ld_word), 128'(32'h55));
        idle();
        chk("stall2_we", 128'(dmem_we), 128'(0));
        send(32'h0000_0066);
        chk("stall3_we",   128'(dmem_we), 128'(1));
        chk("stall3_addr", 128'(ld_addr), 128'(32'h204));
        chk("stall3_word", 128'(ld_word), 128'(32'h66));
        idle();

        // Reset mid-line discards the partial line
        send(32'h0000_0004);
        send(32'h0000_0000);
        send(32'hC000_0000);
        send(32'hC111_1111);
        do_reset();
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        idle();
        idle();
        chk("midrst_no_we", 128'(imem_we), 128'(0));

        // Full load after reset; base 0x34 aligns to line 0x30
        send(32'h0000_0004);
        send(32'h0000_0034);
        send(32'hD000_0000);
        send(32'hD111_1111);
        send(32'hD222_2222);
        send(32'hD333_3333);
        chk("post_we",   128'(imem_we), 128'(1));
        chk("post_addr", 128'(ld_addr), 128'(32'h30));
        chk("post_line", ld_line, {32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333});

        // DONE header
        chk("pre_done_loading", 128'(prog_loading), 128'(1));
        send(32'hC000_0000);
        chk("done_loading", 128'(prog_loading), 128'(0));
        chk("done_ready",   128'(in_ready),     128'(0));
        chk("done_err",     128'(err),          128'(0));
        send(32'h0000_0004);
        send(32'h0000_0000);
        send(32'h4000_0001);
        chk("done_hold_ready",   128'(in_ready),     128'(0));
        chk("done_hold_loading", 128'(prog_loading), 128'(0));
        chk("done_hold_we",      128'({imem_we, dmem_we}), 128'(0));

        // Reserved target after reset
        do_reset();
        chk("rsv_pre_loading", 128'(prog_loading), 128'(1));
        @(negedge clk);
        reset = 1'b0;
        send(32'h8000_0005);
        chk("rsv_err",     128'(err),          128'(1));
        chk("rsv_loading", 128'(prog_loading), 128'(0));
        chk("rsv_ready",   128'(in_ready),     128'(0));
        send(32'h0000_0000);
        send(32'h1234_5678);
        chk("rsv_err_sticky", 128'(err), 128'(1));
        chk("rsv_no_we",      128'({imem_we, dmem_we}), 128'(0));
        do_reset();
        chk("rsv_err_clear", 128'(err), 128'(0));
        chk("rsv_reload",    128'(prog_loading), 128'(1));
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_stream_loader.md
# prog_stream_loader

Parametrised program loader that replaces the tied-off load path in the core top level. It accepts a word stream over a valid/ready handshake, decodes segment headers, packs instruction words into fetch-width lines for instruction memory, writes data words one at a time to data memory, and holds `prog_loading` high until a DONE command arrives. It sits between the host or bench stream source and the imem/dmem write ports, and drives the core reset qualifier.

## Interface
- `INSN_LEN`, 32: stream word and instruction width.
- `FETCH_WIDTH`, 4: instruction words per imem line; power of two, 1..8.
- `ADDR_LEN`, 32: byte-address width of `ld_addr`.
- `CNT_W`, 16: width of the header word-count field.
- `PAD_INSN`, 32'h00000013: fill word for unused lanes of a partial imem line (NOP).

- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: stream word valid.
- `in_data` in INSN_LEN: stream word.
- `in_ready` out 1: loader accepts `in_data` this cycle.
- `prog_loading` out 1: high from reset until DONE is processed.
- `ld_addr` out ADDR_LEN: byte address of the current write.
- `ld_line` out FETCH_WIDTH*INSN_LEN: imem write line; the first word of a line occupies the MSBs.
- `ld_word` out INSN_LEN: dmem write word.
- `imem_we` out 1: one-cycle imem line write strobe.
- `dmem_we` out 1: one-cycle dmem word write strobe.
- `err` out 1: sticky reserved-target error.

## Operation
- Handshake: a word transfers when `in_valid && in_ready`. `in_ready` is 1 in HDR, ADDR and DATA, and 0 in FLUSH and DONE.
- Header word fields:
  - [31:30] target: 00 = imem, 01 = dmem, 11 = DONE, 10 = reserved.
  - [CNT_W-1:0] N = number of data words.
- States and transitions:
  - HDR: on transfer, target 11 -> DONE. Target 10 -> set `err`, go to DONE. Otherwise latch target and N, go to ADDR.
  - ADDR: on transfer, latch base byte address. imem ignores the low log2(FETCH_WIDTH*INSN_LEN/8) bits (line aligned). dmem ignores bits [1:0]. If N == 0 -> HDR, otherwise -> DATA.
  - DATA (dmem): each transfer registers `ld_word`, `ld_addr` = base + 4*k, and pulses `dmem_we`. After the N-th word -> HDR.
  - DATA (imem): words fill lanes 0..FETCH_WIDTH-1, with lane 0 in the MSBs. When a line fills, register `ld_line`, `ld_addr` = base + line_index*FETCH_WIDTH*INSN_LEN/8, and pulse `imem_we`. After the N-th word: if the line is exactly full -> HDR; if partial -> FLUSH.
  - FLUSH: pad the remaining lanes with PAD_INSN, issue one `imem_we`, then -> HDR.
  - DONE: `prog_loading` = 0. Stream is ignored. The state is terminal until `reset`.
- The lane counter and word counter reset at each header. The address offset wraps modulo 2^ADDR_LEN.
- Consecutive segments may target the same addresses; the later write wins at the memory.

## Timing
- Reset values:
  - state = HDR, `prog_loading` = 1, `in_ready` = 1.
  - `imem_we` = `dmem_we` = 0, `err` = 0.
  - `ld_addr` = 0, `ld_line` = 0, `ld_word` = 0.
- All outputs are registered.
- `dmem_we`, `ld_addr` and `ld_word` are valid in the cycle after the transfer of the data word.
- `imem_we` is valid in the cycle after the transfer of the last word of a line, or in the cycle after FLUSH is entered. The strobe lasts exactly 1 cycle.
- `prog_loading` falls in the cycle after the DONE header transfer.
- A back-to-back stream at `in_valid` = 1 incurs no stalls except the single FLUSH cycle.
- `in_valid` low in any state causes no state change and no strobe.
- `reset` asserted mid-segment:
  - Next cycle, every output is at its reset value.
  - Any partial line is discarded (no `imem_we`).
  - `err` clears.

## Test plan
- imem, FETCH_WIDTH=4: header 0x00000004, addr 0x00000000, words A0..A3 -> single `imem_we`, `ld_addr`=0x0, `ld_line`={A0,A1,A2,A3}, no FLUSH cycle.
- imem partial: header 0x00000006, addr 0x00000010, words B0..B5 -> `imem_we` with addr 0x10 line {B0..B3}, then addr 0x20 line {B4,B5,0x13,0x13}. `in_ready` is low exactly one cycle.
- dmem: header 0x40000003, addr 0x00000103, words 0x11, 0x22, 0x33 -> three `dmem_we` pulses at addresses 0x100, 0x104, 0x108 with matching `ld_word`.
- DONE and error: header 0xC0000000 -> `prog_loading` falls the next cycle and `in_ready` stays 0. After reset, header 0x80000005 -> `err`=1, DONE entered, no write strobes.
- Zero count and stalls: header 0x00000000 + addr -> returns to HDR with no strobe. A dmem segment with `in_valid` toggling every cycle -> strobes only follow accepted words.
- Reset mid-line: imem N=4, reset after 2 words -> no `imem_we`, all outputs at reset values, `prog_loading`=1. A subsequent full load completes normally.
